sliscp_perm_ctrl: RTL

//  Drives one sLiSCP-light-256 permutation through the single-step datapath (SLiSCP_step) sitting directly downstream.

---
 rtl/sliscp_pkg.sv | 45 ++++
 rtl/sliscp_perm_ctrl_if.sv | 22 ++
 rtl/sliscp_const_rom.sv | 26 ++
 rtl/sliscp_perm_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/sliscp_pkg.sv
// ============================================================================
//  Module      : sliscp_pkg
//  Description : Shared types and constants for the sLiSCP-light-256
//                permutation controller: FSM encoding, default step and
//                round counts, and the per-step constant table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sliscp_pkg;

    // Controller FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_t;

    localparam int STEPS_DEFAULT  = 18;
    localparam int ROUNDS_DEFAULT = 8;
    localparam int CONST_IDX_W    = $clog2(STEPS_DEFAULT);

    // One entry per step, packed as {rc1, rc0, sc1, sc0}
    localparam logic [0:STEPS_DEFAULT-1][31:0] CONST_TABLE = '{
        32'h27072908, 32'h34041d0c, 32'h2e06170a, 32'h19253b2f,
        32'h35172a38, 32'h0f1c1624, 32'h08123236, 32'h0c3b3a2d,
        32'h0a260e1b, 32'h2f153309, 32'h383f2c11, 32'h24201e0d,
        32'h36302107, 32'h2d282804, 32'h1b3c2606, 32'h09223525,
        32'h11133d17, 32'h0d1a1f1c
    };

    // Constant word for a step; indices past the table read as zero
    function automatic logic [31:0] get_const(input logic [CONST_IDX_W-1:0] step);
        logic [31:0] r;
        r = '0;
        if (32'(step) < STEPS_DEFAULT) begin
            r = CONST_TABLE[step];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sliscp_perm_ctrl_if.sv
// ============================================================================
//  Module      : sliscp_perm_ctrl_if
//  Description : Upstream start/done handshake between sponge/mode logic
//                (master) and the permutation controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sliscp_perm_ctrl_if #(
    parameter int WIDTH = 64
);
    logic                 start;
    logic [4*WIDTH-1:0]   din;
    logic                 busy;
    logic                 done;
    logic [4*WIDTH-1:0]   dout;

    modport master (output start, din, input  busy, done, dout);
    modport slave  (input  start, din, output busy, done, dout);
endinterface

`default_nettype wire

// File: rtl/sliscp_const_rom.sv
// ============================================================================
//  Module      : sliscp_const_rom
//  Description : Combinational lookup of the per-step round and step
//                constants (rc0/rc1/sc0/sc1) from the package table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sliscp_const_rom
    import sliscp_pkg::*;
(
    input  logic [CONST_IDX_W-1:0] step,
    output logic [7:0]             rc0,
    output logic [7:0]             rc1,
    output logic [7:0]             sc0,
    output logic [7:0]             sc1
);

    // Unpack the table word for the requested step
    always_comb begin
        {rc1, rc0, sc1, sc0} = get_const(step);
    end

endmodule

`default_nettype wire

// File: rtl/sliscp_perm_ctrl.sv
// ============================================================================
//  Module      : sliscp_perm_ctrl
//  Description : Sequences one sLiSCP-light-256 permutation through a
//                single-step datapath: holds the 256-bit state, issues
//                per-step constants and the SB round-counter enable, and
//                consumes rnd_done. Optional feature macro: SLISCP_ABORT_EN
//                (adds an abort input that cancels a running permutation).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sliscp_perm_ctrl
    import sliscp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEPS = STEPS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef SLISCP_ABORT_EN
    input  logic                 abort,
`endif
    sliscp_perm_ctrl_if.slave    host,
    output logic [4*WIDTH-1:0]   step_sin,
    input  logic [4*WIDTH-1:0]   step_sout,
    input  logic                 rnd_done,
    output logic                 en_rnd_ctr,
    output logic [7:0]           rc0,
    output logic [7:0]           rc1,
    output logic [7:0]           sc0,
    output logic [7:0]           sc1
);

    localparam int                c_step_w    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [c_step_w-1:0] c_last_step = c_step_w'(STEPS - 1);

    ctrl_state_t           fsm_q, w_fsm_d;
    logic [c_step_w-1:0]   step_q, w_step_d;
    logic [4*WIDTH-1:0]    state_q, w_state_d;
    logic [4*WIDTH-1:0]    dout_q, w_dout_d;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_en;
    logic                  w_abort;
    logic [CONST_IDX_W-1:0] w_const_idx;

`ifdef SLISCP_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // State, step counter, working state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            step_q  <= '0;
            state_q <= '0;
            dout_q  <= '0;
        end else begin
            fsm_q   <= w_fsm_d;
            step_q  <= w_step_d;
            state_q <= w_state_d;
            dout_q  <= w_dout_d;
        end
    end

    // Next-state and output decode; LOAD is the one-cycle SB counter clear
    always_comb begin
        w_fsm_d   = fsm_q;
        w_step_d  = step_q;
        w_state_d = state_q;
        w_dout_d  = dout_q;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_en      = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (host.start) begin
                    w_state_d = host.din;
                    w_step_d  = '0;
                    w_fsm_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_busy = 1'b1;
                if (w_abort) begin
                    w_step_d = '0;
                    w_fsm_d  = ST_IDLE;
                end else begin
                    w_fsm_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                w_en   = 1'b1;
                if (w_abort) begin
                    w_step_d = '0;
                    w_fsm_d  = ST_IDLE;
                end else if (rnd_done) begin
                    w_state_d = step_sout;
                    if (step_q == c_last_step) begin
                        w_dout_d = step_sout;
                        w_step_d = '0;
                        w_fsm_d  = ST_DONE;
                    end else begin
                        w_step_d = step_q + 1'b1;
                        w_fsm_d  = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (host.start) begin
                    w_state_d = host.din;
                    w_step_d  = '0;
                    w_fsm_d   = ST_LOAD;
                end else begin
                    w_fsm_d   = ST_IDLE;
                end
            end
            default: begin
                w_fsm_d = ST_IDLE;
            end
        endcase
    end

    assign w_const_idx = CONST_IDX_W'(step_q);

    sliscp_const_rom u_const_rom (
        .step (w_const_idx),
        .rc0  (rc0),
        .rc1  (rc1),
        .sc0  (sc0),
        .sc1  (sc1)
    );

    assign host.busy  = w_busy;
    assign host.done  = w_done;
    assign host.dout  = dout_q;
    assign step_sin   = state_q;
    assign en_rnd_ctr = w_en;

endmodule

`default_nettype wire
